di_mem_terminal: RTL and testbench

- Device-interface (di_*) responder: the terminal end of the host-interface initiator bus.
- Bridges di read/write transfers addressed to its terminal onto a variable-latency word memory port (req/ack).
- Generates di_read_rdy, di_write_rdy and di_transfer_status, including range and timeout error reporting.
- Instantiated in the fpga top beside the other terminals; its outputs feed the top-level di return mux.

---
 rtl/di_mem_terminal_pkg.sv | 23 ++
 rtl/di_timeout_counter.sv | 27 ++
 rtl/di_mem_terminal.sv | 139 +++++++++++++
 tb/tb_di_mem_terminal.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/di_mem_terminal_pkg.sv
// Shared types and constants for the di memory terminal.
// State encoding, status bit positions and read fill words.
package di_mem_terminal_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_VALID = 2'd2,
        WR_WAIT  = 2'd3
    } state_t;

    localparam int ST_RANGE   = 0;
    localparam int ST_TIMEOUT = 1;

    localparam logic [15:0] FILL_RANGE   = 16'hDEAD;
    localparam logic [15:0] FILL_TIMEOUT = 16'hBAD0;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int aw);
        return (addr >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/di_timeout_counter.sv
// Saturating 8-bit wait counter; expired flags the cycle in which
// the count would reach TIMEOUT so the request can be dropped on that edge.
module di_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic ifclk,
    input  logic resetb,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = enable && (({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT));

endmodule

// File: rtl/di_mem_terminal.sv
// di bus responder bridging selected read/write transfers onto a
// req/ack word memory, with sticky range and timeout status.
module di_mem_terminal
    import di_mem_terminal_pkg::*;
#(
    parameter logic [15:0] TERM_ADDR  = 16'h0010,
    parameter int          ADDR_WIDTH = 12,
    parameter int          TIMEOUT    = 255
) (
    input  logic                  ifclk,
    input  logic                  resetb,
    input  logic [15:0]           di_term_addr,
    input  logic [31:0]           di_reg_addr,
    input  logic [31:0]           di_len,
    input  logic                  di_read_mode,
    input  logic                  di_read_req,
    input  logic                  di_read,
    input  logic                  di_write_mode,
    input  logic                  di_write,
    input  logic [15:0]           di_reg_datai,
    output logic [15:0]           di_reg_datao,
    output logic                  di_read_rdy,
    output logic                  di_write_rdy,
    output logic [15:0]           di_transfer_status,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ack
);

    state_t      state;
    logic        mode_q;
    logic        mode_rise;
    logic        sel;
    logic        in_rng;
    logic        rd_go;
    logic        wr_go;
    logic        wr_clash;
    logic        mem_go;
    logic        waiting;
    logic        expired;
    logic [15:0] st_set;
    logic        unused_ok;

    assign sel       = di_term_addr == TERM_ADDR;
    assign in_rng    = addr_in_range(di_reg_addr, ADDR_WIDTH);
    assign waiting   = state == RD_WAIT || state == WR_WAIT;
    assign rd_go     = sel && di_read_req
                       && (state == IDLE || state == RD_VALID);
    assign wr_go     = sel && di_write && !di_read_req && state == IDLE;
    assign wr_clash  = sel && di_write && di_read_req && state == IDLE;
    assign mem_go    = (rd_go || wr_go) && in_rng;
    assign mode_rise = (di_read_mode || di_write_mode) && !mode_q;
    assign unused_ok = ^di_len;

    // Held low while reset is asserted so every non-write-ready output reads 0.
    assign di_read_rdy  = resetb && (state == IDLE || state == RD_VALID)
                          && !(sel && di_read_req);
    assign di_write_rdy = state == IDLE && !(sel && di_write);

    always_comb begin
        st_set             = '0;
        st_set[ST_RANGE]   = ((rd_go || wr_go) && !in_rng) || wr_clash;
        st_set[ST_TIMEOUT] = waiting && !mem_ack && expired;
    end

    di_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .ifclk  (ifclk),
        .resetb (resetb),
        .clear  (mem_go),
        .enable (waiting),
        .expired(expired)
    );

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state              <= IDLE;
            mode_q             <= 1'b0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            di_reg_datao       <= '0;
            di_transfer_status <= '0;
        end else begin
            mode_q             <= di_read_mode || di_write_mode;
            di_transfer_status <= (mode_rise ? 16'h0000 : di_transfer_status)
                                  | st_set;
            unique case (state)
                IDLE, RD_VALID: begin
                    if (rd_go) begin
                        if (in_rng) begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= di_reg_addr[ADDR_WIDTH-1:0];
                            state    <= RD_WAIT;
                        end else begin
                            di_reg_datao <= FILL_RANGE;
                            state        <= RD_VALID;
                        end
                    end else if (wr_go) begin
                        if (in_rng) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= di_reg_addr[ADDR_WIDTH-1:0];
                            mem_wdata <= di_reg_datai;
                            state     <= WR_WAIT;
                        end
                    end else if (state == RD_VALID && sel && di_read) begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        di_reg_datao <= mem_rdata;
                        mem_req      <= 1'b0;
                        state        <= RD_VALID;
                    end else if (expired) begin
                        di_reg_datao <= FILL_TIMEOUT;
                        mem_req      <= 1'b0;
                        state        <= RD_VALID;
                    end
                end
                WR_WAIT: begin
                    if (mem_ack || expired) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_di_mem_terminal.sv
// Directed bench for di_mem_terminal: vector table plus hand sequences
// for back-to-back reads, timeout, late ack, clash and async reset.
module tb_di_mem_terminal;

    localparam logic [15:0] TERM  = 16'h0010;
    localparam logic [15:0] OTHER = 16'h0011;
    localparam int          NV    = 10;

    logic        ifclk;
    logic        resetb;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    logic        di_write_mode;
    logic        di_write;
    logic [15:0] di_reg_datai;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy;
    logic        di_write_rdy;
    logic [15:0] di_transfer_status;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    di_mem_terminal #(
        .TERM_ADDR (16'h0010),
        .ADDR_WIDTH(12),
        .TIMEOUT   (255)
    ) dut (
        .ifclk             (ifclk),
        .resetb            (resetb),
        .di_term_addr      (di_term_addr),
        .di_reg_addr       (di_reg_addr),
        .di_len            (di_len),
        .di_read_mode      (di_read_mode),
        .di_read_req       (di_read_req),
        .di_read           (di_read),
        .di_write_mode     (di_write_mode),
        .di_write          (di_write),
        .di_reg_datai      (di_reg_datai),
        .di_reg_datao      (di_reg_datao),
        .di_read_rdy       (di_read_rdy),
        .di_write_rdy      (di_write_rdy),
        .di_transfer_status(di_transfer_status),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    initial ifclk = 1'b0;
    always #5 ifclk = ~ifclk;

    // Memory model: acks after ack_dly waiting cycles when enabled.
    logic [15:0] mem [0:4095];
    int          ack_dly    = 0;
    bit          ack_en     = 1'b1;
    int          late_req   = 0;
    int          late_done  = 0;
    int          req_cycles = 0;
    int          wr_cnt     = 0;
    int          wcnt       = 0;
    logic [11:0] wr_addr    = '0;
    logic [15:0] wr_data    = '0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int k = 0; k < 4096; k++) mem[k] = 16'h0000;
        mem[0] = 16'hC0DE;
        for (int k = 10; k < 18; k++) mem[k] = 16'h1000 + 16'(k);
        forever begin
            @(negedge ifclk);
            mem_ack = 1'b0;
            if (late_req != late_done) begin
                mem_ack   = 1'b1;
                late_done = late_req;
            end else if (mem_req) begin
                req_cycles++;
                if (ack_en && wcnt == ack_dly) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wr_addr       = mem_addr;
                        wr_data       = mem_wdata;
                        wr_cnt++;
                    end else begin
                        mem_rdata = mem[mem_addr];
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [15:0] term;
        logic [31:0] addr;
        logic [15:0] wdata;
        int          dly;
        logic [15:0] exp_data;
        logic [15:0] exp_status;
        bit          exp_mem;
        bit          chk_data;
    } vec_t;

    vec_t        vecs [NV];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] d;
    int          r0;
    int          w0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_read(output logic [15:0] rd);
        int n;
        n = 0;
        while (!di_read_rdy && n < 400) begin
            @(negedge ifclk);
            n++;
        end
        chk("rd_bound", 32'(n < 400), 32'd1);
        rd = di_reg_datao;
    endtask

    task automatic do_read(input logic [15:0] term, input logic [31:0] addr,
                           output logic [15:0] rd);
        di_term_addr = term;
        di_reg_addr  = addr;
        di_read_req  = 1'b1;
        @(negedge ifclk);
        di_read_req = 1'b0;
        wait_read(rd);
        di_read = 1'b1;
        @(negedge ifclk);
        di_read      = 1'b0;
        di_term_addr = TERM;
    endtask

    task automatic do_write(input logic [15:0] term, input logic [31:0] addr,
                            input logic [15:0] data);
        int n;
        di_term_addr = term;
        di_reg_addr  = addr;
        di_reg_datai = data;
        di_write     = 1'b1;
        @(negedge ifclk);
        di_write = 1'b0;
        n = 0;
        while (!di_write_rdy && n < 400) begin
            @(negedge ifclk);
            n++;
        end
        chk("wr_bound", 32'(n < 400), 32'd1);
        di_term_addr = TERM;
    endtask

    task automatic mode_start(input bit wr);
        di_read_mode  = 1'b0;
        di_write_mode = 1'b0;
        @(negedge ifclk);
        if (wr) di_write_mode = 1'b1;
        else    di_read_mode  = 1'b1;
        @(negedge ifclk);
        chk("status_clr", 32'(di_transfer_status), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        resetb        = 1'b0;
        di_term_addr  = TERM;
        di_reg_addr   = '0;
        di_len        = 32'd2;
        di_read_mode  = 1'b0;
        di_read_req   = 1'b0;
        di_read       = 1'b0;
        di_write_mode = 1'b0;
        di_write      = 1'b0;
        di_reg_datai  = '0;

        vecs[0] = '{1'b1, TERM,  32'd5,          16'h1234, 3, 16'h0,    16'h0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, TERM,  32'd5,          16'h0,    0, 16'h1234, 16'h0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, TERM,  32'd4096,       16'h0,    0, 16'hDEAD, 16'h1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, TERM,  32'd4096,       16'h5555, 0, 16'h0,    16'h1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, OTHER, 32'd5,          16'h0,    0, 16'h0,    16'h0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, OTHER, 32'd6,          16'h7777, 0, 16'h0,    16'h0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, TERM,  32'h8000_0005,  16'h0,    0, 16'hDEAD, 16'h1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, TERM,  32'd4095,       16'hBEEF, 1, 16'h0,    16'h0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, TERM,  32'd4095,       16'h0,    2, 16'hBEEF, 16'h0, 1'b1, 1'b1};
        vecs[9] = '{1'b0, TERM,  32'd0,          16'h0,    5, 16'hC0DE, 16'h0, 1'b1, 1'b1};

        repeat (3) @(negedge ifclk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_datao", 32'(di_reg_datao), 32'd0);
        chk("rst_status", 32'(di_transfer_status), 32'd0);
        chk("rst_read_rdy", 32'(di_read_rdy), 32'd0);
        chk("rst_write_rdy", 32'(di_write_rdy), 32'd1);
        resetb = 1'b1;
        @(negedge ifclk);

        for (int i = 0; i < NV; i++) begin
            ack_dly = vecs[i].dly;
            ack_en  = 1'b1;
            mode_start(vecs[i].wr);
            r0 = req_cycles;
            w0 = wr_cnt;
            if (vecs[i].wr) do_write(vecs[i].term, vecs[i].addr, vecs[i].wdata);
            else            do_read(vecs[i].term, vecs[i].addr, d);
            chk($sformatf("v%0d_status", i), 32'(di_transfer_status),
                32'(vecs[i].exp_status));
            chk($sformatf("v%0d_mem", i), 32'(req_cycles != r0),
                32'(vecs[i].exp_mem));
            chk($sformatf("v%0d_idle", i), 32'(di_write_rdy), 32'd1);
            if (!vecs[i].wr && vecs[i].chk_data)
                chk($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
            if (vecs[i].wr && vecs[i].exp_mem) begin
                chk($sformatf("v%0d_waddr", i), 32'(wr_addr),
                    vecs[i].addr & 32'hFFF);
                chk($sformatf("v%0d_wdata", i), 32'(wr_data),
                    32'(vecs[i].wdata));
                chk($sformatf("v%0d_wcnt", i), 32'(wr_cnt - w0), 32'd1);
            end
        end

        // Zero-wait back-to-back reads, consume and request together.
        ack_dly = 0;
        mode_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            di_reg_addr = 32'd10 + 32'(i);
            di_read_req = 1'b1;
            di_read     = (i > 0);
            #1;
            chk($sformatf("b2b%0d_rdy_req", i), 32'(di_read_rdy), 32'd0);
            @(negedge ifclk);
            di_read_req = 1'b0;
            di_read     = 1'b0;
            chk($sformatf("b2b%0d_req", i), 32'(mem_req), 32'd1);
            @(negedge ifclk);
            chk($sformatf("b2b%0d_rdy", i), 32'(di_read_rdy), 32'd1);
            chk($sformatf("b2b%0d_data", i), 32'(di_reg_datao),
                32'(16'h100A + 16'(i)));
        end
        di_read = 1'b1;
        @(negedge ifclk);
        di_read = 1'b0;

        // Read and write in the same cycle: read proceeds, write dropped.
        mode_start(1'b0);
        w0           = wr_cnt;
        di_reg_addr  = 32'd5;
        di_reg_datai = 16'h9999;
        di_read_req  = 1'b1;
        di_write     = 1'b1;
        @(negedge ifclk);
        di_read_req = 1'b0;
        di_write    = 1'b0;
        wait_read(d);
        chk("clash_data", 32'(d), 32'h1234);
        chk("clash_status", 32'(di_transfer_status), 32'h1);
        chk("clash_nowrite", 32'(wr_cnt - w0), 32'd0);
        di_read = 1'b1;
        @(negedge ifclk);
        di_read = 1'b0;

        // Withheld ack: abort after 255 request cycles, then a late ack.
        ack_en = 1'b0;
        mode_start(1'b0);
        r0          = req_cycles;
        di_reg_addr = 32'd7;
        di_read_req = 1'b1;
        @(negedge ifclk);
        di_read_req = 1'b0;
        wait_read(d);
        chk("tmo_req_cycles", 32'(req_cycles - r0), 32'd255);
        chk("tmo_data", 32'(d), 32'hBAD0);
        chk("tmo_status", 32'(di_transfer_status), 32'h2);
        di_read = 1'b1;
        @(negedge ifclk);
        di_read = 1'b0;
        late_req++;
        repeat (2) @(negedge ifclk);
        chk("late_req", 32'(mem_req), 32'd0);
        chk("late_read_rdy", 32'(di_read_rdy), 32'd1);
        chk("late_write_rdy", 32'(di_write_rdy), 32'd1);
        chk("late_datao", 32'(di_reg_datao), 32'hBAD0);
        chk("late_status", 32'(di_transfer_status), 32'h2);

        // Async reset while waiting on memory.
        mode_start(1'b0);
        di_reg_addr = 32'd0;
        di_read_req = 1'b1;
        @(negedge ifclk);
        di_read_req = 1'b0;
        repeat (3) @(negedge ifclk);
        chk("mid_req", 32'(mem_req), 32'd1);
        resetb = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_datao", 32'(di_reg_datao), 32'd0);
        chk("arst_status", 32'(di_transfer_status), 32'd0);
        chk("arst_write_rdy", 32'(di_write_rdy), 32'd1);
        @(negedge ifclk);
        resetb  = 1'b1;
        ack_en  = 1'b1;
        ack_dly = 0;
        @(negedge ifclk);
        do_read(TERM, 32'd0, d);
        chk("post_rst_data", 32'(d), 32'hC0DE);
        chk("post_rst_status", 32'(di_transfer_status), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
